// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Operation codes, FSM states and default operand width.
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's-complement magnitude when the value is treated as signed
  function automatic logic [WIDTH_DEF-1:0] mag(
    input logic                 sgn,
    input logic [WIDTH_DEF-1:0] v
  );
    return (sgn && v[WIDTH_DEF-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_core.sv
// Unsigned iterative datapath: shift-add multiply and
// restoring divide sharing one 33-bit adder/subtractor.
module mult_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES - 1);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0] add_a;
  logic [WIDTH:0] add_b;
  logic [WIDTH:0] sum;

  // Shared adder: add for multiply, trial subtract for divide
  always_comb begin
    if (is_div) begin
      add_a = {hi_q, lo_q[WIDTH-1]};
      add_b = ~{1'b0, b_q};
    end else begin
      add_a = {1'b0, hi_q};
      add_b = lo_q[0] ? {1'b0, b_q} : '0;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, is_div};
  end

  // Next-state of the shift registers and iteration counter
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = a_in;
      b_d   = b_in;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div) begin
        if (!sum[WIDTH]) begin
          hi_d = sum[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = add_a[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with start/busy/done
// handshake; signs are stripped on entry and restored in FIX.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CYCLES = WIDTH
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result
);

  state_e state_q, state_d;
  logic   div_q, div_d;
  logic   sgn_q, sgn_d;
  logic   neg_q, neg_d;
  logic   rneg_q, rneg_d;
  logic   bz_q, bz_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic             load;
  logic             step;
  logic             last;
  logic             in_sgn;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] fixed;

  assign in_sgn = ~Op[0];
  assign a_abs  = in_sgn && A[WIDTH-1] ? -A : A;
  assign b_abs  = in_sgn && B[WIDTH-1] ? -B : B;

  mult_div_core #(
    .WIDTH (WIDTH),
    .CYCLES(CYCLES)
  ) u_core (
    .clk   (Clk),
    .rst   (Rst),
    .load  (load),
    .step  (step),
    .is_div(div_q),
    .a_in  (a_abs),
    .b_in  (b_abs),
    .hi    (hi),
    .lo    (lo),
    .last  (last)
  );

  // Sign restoration; divide-by-zero keeps the all-ones quotient
  always_comb begin
    prod = {hi, lo};
    quo  = lo;
    rem  = hi;
    if (sgn_q && neg_q) prod = -{hi, lo};
    if (sgn_q && neg_q && !bz_q) quo = -lo;
    if (sgn_q && rneg_q) rem = -hi;
    fixed = div_q ? {rem, quo} : prod;
  end

  // Handshake FSM next-state and operand sign capture
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          load    = 1'b1;
          div_d   = Op[1];
          sgn_d   = in_sgn;
          neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
          rneg_d  = A[WIDTH-1];
          bz_d    = (B == '0);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_d = FIX;
      end
      FIX: begin
        result_d = fixed;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule
